// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC datapath constants and helpers.
package mini_src_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned NUM_GPR    = 16;
    localparam int unsigned R0_ADDR    = 0;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write/read port bundle of the general-purpose register file.
interface register_file_if
    import mini_src_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH,
    parameter int unsigned DEPTH = NUM_GPR
);
    localparam int unsigned AW = clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic             ba;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic [DEPTH-1:0] valid;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, ba,
        input  rdata_a, rdata_b, valid
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, ba,
        output rdata_a, rdata_b, valid
    );

endinterface

// File: rtl/register_n.sv
// Single WIDTH-bit register with async active-low clear, write enable and
// a "written since clear" flag.
module register_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Clear dominates; a write loads data and marks the register as written.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            data_q  <= d;
            valid_q <= 1'b1;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational
// read ports with optional write-through bypass and R0 base-address zeroing.
module register_file
    import mini_src_pkg::*;
#(
    parameter int unsigned WIDTH   = WORD_WIDTH,
    parameter int unsigned DEPTH   = NUM_GPR,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input logic            clk,
    input logic            clr,
    register_file_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW-1:0] R0 = AW'(R0_ADDR);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("register_file: DEPTH must be a power of two and at least 2");
    end

    logic [DEPTH-1:0] wen;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] valid_bits;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // One-hot write decode; clear is applied inside each register.
    always_comb begin
        wen = '0;
        if (bus.we) begin
            wen[bus.waddr] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        register_n #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk   (clk),
            .clr   (clr),
            .en    (wen[i]),
            .d     (bus.wdata),
            .q     (regs[i]),
            .valid (valid_bits[i])
        );
    end

    // Port A: clear, then R0 gate, then bypass, then stored value.
    always_comb begin
        rd_a = regs[bus.raddr_a];
        if (!clr) begin
            rd_a = '0;
        end else if (ZERO_R0 && bus.ba && (bus.raddr_a == R0)) begin
            rd_a = '0;
        end else if (BYPASS && bus.we && (bus.waddr == bus.raddr_a)) begin
            rd_a = bus.wdata;
        end
    end

    // Port B: same priority as port A, fully independent.
    always_comb begin
        rd_b = regs[bus.raddr_b];
        if (!clr) begin
            rd_b = '0;
        end else if (ZERO_R0 && bus.ba && (bus.raddr_b == R0)) begin
            rd_b = '0;
        end else if (BYPASS && bus.we && (bus.waddr == bus.raddr_b)) begin
            rd_b = bus.wdata;
        end
    end

    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;
    assign bus.valid   = valid_bits;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: two DUTs (bypass on / off) share stimulus; expectations
// are queued by the stimulus and checked by an independent monitor.
module tb_register_file;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    localparam int unsigned F_RA = 0;
    localparam int unsigned F_RB = 1;
    localparam int unsigned F_VL = 2;

    typedef struct {
        int unsigned dut;
        int unsigned field;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic             clk;
    logic             clr;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic             ba;

    exp_t sb[$];
    event sample_ev;
    int   total;
    int   bad;

    register_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
    register_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

    assign bus0.we      = we;
    assign bus0.waddr   = waddr;
    assign bus0.wdata   = wdata;
    assign bus0.raddr_a = raddr_a;
    assign bus0.raddr_b = raddr_b;
    assign bus0.ba      = ba;
    assign bus1.we      = we;
    assign bus1.waddr   = waddr;
    assign bus1.wdata   = wdata;
    assign bus1.raddr_a = raddr_a;
    assign bus1.raddr_b = raddr_b;
    assign bus1.ba      = ba;

    register_file #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .BYPASS  (1'b1),
        .ZERO_R0 (1'b1)
    ) dut0 (
        .clk (clk),
        .clr (clr),
        .bus (bus0)
    );

    register_file #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .BYPASS  (1'b0),
        .ZERO_R0 (1'b1)
    ) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int unsigned d, input int unsigned f);
        logic [31:0] v;
        v = '0;
        if (d == 0) begin
            case (f)
                F_RA:    v = bus0.rdata_a;
                F_RB:    v = bus0.rdata_b;
                default: v = 32'(bus0.valid);
            endcase
        end else begin
            case (f)
                F_RA:    v = bus1.rdata_a;
                F_RB:    v = bus1.rdata_b;
                default: v = 32'(bus1.valid);
            endcase
        end
        return v;
    endfunction

    // Monitor: on every sample strobe, drain the queue and compare.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() != 0) begin
                e   = sb.pop_front();
                act = actual(e.dut, e.field);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s dut%0d: got %h expected %h at %0t",
                             e.name, e.dut, act, e.exp, $time);
                end
            end
        end
    end

    task automatic push(input int unsigned d, input int unsigned f, input logic [31:0] v,
                        input string name);
        exp_t e;
        e.dut   = d;
        e.field = f;
        e.exp   = v;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic push2(input int unsigned f, input logic [31:0] v, input string name);
        push(0, f, v, name);
        push(1, f, v, name);
    endtask

    // Let combinational outputs settle, then strobe the monitor.
    task automatic sample();
        #1;
        ->sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        clr     = 1'b0;
        we      = 1'b1;
        waddr   = 4'd5;
        wdata   = 32'hDEADBEEF;
        raddr_a = 4'd5;
        raddr_b = 4'd5;
        ba      = 1'b0;

        // Reset held with write attempts: nothing sticks, bypass suppressed.
        repeat (3) begin
            tick();
            push2(F_RA, 32'h0, "reset_rdata_a");
            push2(F_RB, 32'h0, "reset_rdata_b");
            push2(F_VL, 32'h0, "reset_valid");
            sample();
        end
        we  = 1'b0;
        clr = 1'b1;
        tick();

        // Back-to-back writes to R5.
        we    = 1'b1;
        waddr = 4'd5;
        wdata = 32'h11111111;
        tick();
        wdata = 32'h11110000;
        push(1, F_RA, 32'h11111111, "r5_first_stored");
        push(0, F_RA, 32'h11110000, "r5_second_bypass");
        sample();
        tick();
        we = 1'b0;
        push2(F_RA, 32'h11110000, "r5_second_stored");
        push2(F_VL, 32'h0020, "r5_valid");
        sample();

        // Bypass versus stored value on port B.
        we      = 1'b1;
        waddr   = 4'd3;
        wdata   = 32'hA5A5A5A5;
        raddr_b = 4'd3;
        push(0, F_RB, 32'hA5A5A5A5, "bypass_on_pre_edge");
        push(1, F_RB, 32'h0, "bypass_off_pre_edge");
        sample();
        tick();
        we = 1'b0;
        push2(F_RB, 32'hA5A5A5A5, "r3_post_edge");
        push2(F_VL, 32'h0028, "r3_valid");
        sample();

        // R0 gating.
        we      = 1'b1;
        waddr   = 4'd0;
        wdata   = 32'h42;
        raddr_a = 4'd0;
        raddr_b = 4'd0;
        tick();
        we = 1'b0;
        push2(F_RA, 32'h42, "r0_ba0_a");
        push2(F_RB, 32'h42, "r0_ba0_b");
        sample();
        ba = 1'b1;
        push2(F_RA, 32'h0, "r0_ba1_a");
        push2(F_RB, 32'h0, "r0_ba1_b");
        sample();
        we    = 1'b1;
        wdata = 32'h77;
        push2(F_RA, 32'h0, "r0_ba1_wr_a");
        push2(F_RB, 32'h0, "r0_ba1_wr_b");
        sample();
        tick();
        we = 1'b0;
        ba = 1'b0;
        push2(F_RA, 32'h77, "r0_after_wr_a");
        push2(F_RB, 32'h77, "r0_after_wr_b");
        sample();

        // Fill every register, then sweep both ports in opposite directions.
        for (int i = 0; i < 16; i++) begin
            we    = 1'b1;
            waddr = AW'(i);
            wdata = 32'h1000 + 32'(i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(15 - i);
            push2(F_RA, 32'h1000 + 32'(i), "sweep_a");
            push2(F_RB, 32'h1000 + 32'(15 - i), "sweep_b");
            sample();
        end
        push2(F_VL, 32'hFFFF, "full_valid");
        sample();

        // Async clear while clk is low, checked before the next rising edge.
        raddr_a = 4'd7;
        raddr_b = 4'd12;
        @(negedge clk);
        push2(F_RA, 32'h1007, "preclear_a");
        sample();
        clr = 1'b0;
        push2(F_RA, 32'h0, "midclear_a");
        push2(F_RB, 32'h0, "midclear_b");
        push2(F_VL, 32'h0, "midclear_valid");
        sample();
        tick();
        clr = 1'b1;
        tick();
        we    = 1'b1;
        waddr = 4'd2;
        wdata = 32'h9;
        tick();
        we      = 1'b0;
        raddr_a = 4'd2;
        push2(F_VL, 32'h0004, "post_clear_valid");
        push2(F_RA, 32'h9, "post_clear_r2");
        push2(F_RB, 32'h0, "post_clear_r12");
        sample();

        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
